// File: rtl/sprite_rom_arb_pkg.sv
// Shared sprite package: arbiter parameter defaults, palette constants and
// small sizing helpers used by the sprite ROM arbiter and its sub-module.
package sprite_rom_arb_pkg;

    localparam int NREQ_DEF    = 4;
    localparam int ADDR_W_DEF  = 8;
    localparam int DATA_W_DEF  = 4;
    localparam int ROM_LAT_DEF = 1;
    localparam int ROM_LAT_MAX = 3;

    // Colour indices stored in the sprite image ROM; index 0 is see-through.
    typedef enum logic [3:0] {
        PAL_CLEAR   = 4'h0,
        PAL_BLACK   = 4'h1,
        PAL_WHITE   = 4'h2,
        PAL_RED     = 4'h3,
        PAL_GREEN   = 4'h4,
        PAL_BLUE    = 4'h5,
        PAL_YELLOW  = 4'h6,
        PAL_CYAN    = 4'h7,
        PAL_MAGENTA = 4'h8,
        PAL_ORANGE  = 4'h9,
        PAL_GREY    = 4'hA,
        PAL_DGREY   = 4'hB,
        PAL_LRED    = 4'hC,
        PAL_LGREEN  = 4'hD,
        PAL_LBLUE   = 4'hE,
        PAL_BROWN   = 4'hF
    } palette_e;

    localparam logic [11:0] PALETTE_RGB [16] = '{
        12'h000, 12'h000, 12'hFFF, 12'hF00,
        12'h0F0, 12'h00F, 12'hFF0, 12'h0FF,
        12'hF0F, 12'hF80, 12'h888, 12'h444,
        12'hF88, 12'h8F8, 12'h88F, 12'h840
    };

    function automatic logic [11:0] palette_rgb(input palette_e idx);
        return PALETTE_RGB[idx];
    endfunction

    function automatic bit palette_is_clear(input palette_e idx);
        return idx == PAL_CLEAR;
    endfunction

    // Width of a requester index; a single requester still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_rom_arb_rr_pick.sv
// Combinational round-robin winner search with an optional fixed-priority
// override for requester 0 (the player ship).
module rr_pick
    import sprite_rom_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int IDX_W = idx_w(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    input  logic             pri_en,
    output logic [NREQ-1:0]  pick,
    output logic [IDX_W-1:0] pick_idx,
    output logic             any
);

    int cand;

    // NOTE: every output gets a default before any branch, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        cand     = 0;
        any      = |req;
        if (pri_en && req[0]) begin
            pick[0] = 1'b1;
        end else begin
            // Walk from the farthest candidate inwards so the nearest one
            // after the pointer is the last hit and therefore the winner.
            for (int k = NREQ; k >= 1; k--) begin
                cand = (int'(last) + k) % NREQ;
                if (req[cand]) begin
                    pick       = '0;
                    pick[cand] = 1'b1;
                    pick_idx   = IDX_W'(cand);
                end
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arb.sv
// Shared sprite image ROM arbiter: one grant per cycle, round-robin with an
// optional player-ship priority, responses tagged back through a pipeline.
module sprite_rom_arb
    import sprite_rom_arb_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ROM_LAT = ROM_LAT_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic                   pri_en,
    output logic [NREQ-1:0]        gnt,
    output logic [ADDR_W-1:0]      rom_addr,
    input  logic [DATA_W-1:0]      rom_q,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_data
);

    localparam int IDX_W = idx_w(NREQ);

    logic [IDX_W-1:0]  last_winner;
    logic [NREQ-1:0]   pick;
    logic [IDX_W-1:0]  pick_idx;
    logic              any;
    logic [ADDR_W-1:0] win_addr;

    // Stage 0 lines up with gnt; stage ROM_LAT lines up with valid rom_q.
    logic [ROM_LAT:0]  tag_v;
    logic [IDX_W-1:0]  tag_idx [ROM_LAT+1];

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req      (req),
        .last     (last_winner),
        .pri_en   (pri_en),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (any)
    );

    always_comb begin
        win_addr = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gnt         <= '0;
            rom_addr    <= '0;
            last_winner <= IDX_W'(NREQ - 1);
        end else begin
            gnt <= pick;
            if (any) begin
                rom_addr    <= win_addr;
                last_winner <= pick_idx;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tag_v <= '0;
        end else begin
            tag_v <= {tag_v[ROM_LAT-1:0], any};
        end
    end

    // NOTE: the index payload is left out of reset; it is only ever consumed
    // alongside its valid bit, which is cleared asynchronously.
    always_ff @(posedge clock) begin
        tag_idx[0] <= pick_idx;
        for (int k = 1; k <= ROM_LAT; k++) begin
            tag_idx[k] <= tag_idx[k-1];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= tag_v[ROM_LAT] ? (NREQ'(1) << tag_idx[ROM_LAT]) : '0;
            if (tag_v[ROM_LAT]) begin
                rsp_data <= rom_q;
            end
        end
    end

endmodule

// File: doc/sprite_rom_arb.md
SPRITE_ROM_ARB -- requirements
Module: sprite_rom_arb

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of sprite requesters.
REQ-002 The block SHALL have parameter ADDR_W, default 8, giving the sprite image ROM address width.
REQ-003 The block SHALL have parameter DATA_W, default 4, giving the width of the ROM color index.
REQ-004 The block SHALL have parameter ROM_LAT, default 1, giving the external ROM read latency in clock cycles (range 1..3).
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock; all logic is rising-edge triggered.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port req, input, NREQ bits: per-requester read request, sampled every rising edge.
REQ-008 The block SHALL have port req_addr, input, NREQ*ADDR_W bits: requester i address in slice [i*ADDR_W +: ADDR_W].
REQ-009 The block SHALL have port pri_en, input, 1 bit: when high, requester 0 (player ship) has fixed top priority.
REQ-010 The block SHALL have port gnt, output, NREQ bits: one-hot grant pulse, at most one bit set.
REQ-011 The block SHALL have port rom_addr, output, ADDR_W bits: address to the shared image ROM.
REQ-012 The block SHALL have port rom_q, input, DATA_W bits: ROM read data, valid ROM_LAT cycles after rom_addr.
REQ-013 The block SHALL have port rsp_valid, output, NREQ bits: one-hot, one-cycle response strobe.
REQ-014 The block SHALL have port rsp_data, output, DATA_W bits: registered ROM data for the requester flagged in rsp_valid.

Function
REQ-015 At each rising edge with any req bit high, the block SHALL pick exactly one winner; gnt and rom_addr SHALL be registered so that they appear in cycle T+1 for a request sampled at edge T.
REQ-016 The winner SHALL be chosen round-robin: the search starts at (last_winner+1) mod NREQ and wraps around.
REQ-017 When pri_en is high and req[0] is high, requester 0 SHALL win regardless of pointer, and last_winner SHALL update to 0.
REQ-018 Every req bit high at a sampling edge SHALL be a new request; a requester still asserting req during its gnt cycle SHALL be treated as issuing a back-to-back request.
REQ-019 gnt SHALL be a single-cycle pulse; with no requests, gnt SHALL be 0 and rom_addr SHALL hold its last value.
REQ-020 A tag pipeline of depth ROM_LAT+1 SHALL carry the winner index and valid bit, so that rsp_valid[w] and rsp_data (rom_q registered) appear exactly ROM_LAT+1 cycles after gnt[w].
REQ-021 Throughput SHALL be one grant per cycle; responses SHALL return in grant order with no gaps inserted.
REQ-022 Under continuous requests from all NREQ requesters, each requester SHALL be granted exactly once in every NREQ consecutive grants (pri_en low).
REQ-023 Under all requests with pri_en high and req[0] continuously high, only requester 0 SHALL be granted (starvation of others is accepted by design).
REQ-024 A request whose req bit drops before the sampling edge SHALL be ignored; no partial state SHALL result.

Reset
REQ-025 When reset is low, gnt, rsp_valid, rsp_data, rom_addr and all tag-pipeline valid bits SHALL be 0 immediately (asynchronously).
REQ-026 At reset, last_winner SHALL be NREQ-1, so requester 0 wins the first contended round.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight responses; no rsp_valid SHALL appear for grants issued before reset.

Structure
REQ-028 NREQ default, ADDR_W, DATA_W and ROM_LAT defaults SHALL live in the shared sprite package alongside the palette constants.
REQ-029 The round-robin winner search (req, pointer, pri_en -> one-hot, index) SHALL be a combinational sub-module named rr_pick; the pipeline and registers remain in sprite_rom_arb.

Verification
REQ-030 Single request: req=4'b0100, addr2=8'h3A for one cycle -> gnt=4'b0100 at T+1, rom_addr=8'h3A; with ROM returning 4'h9, rsp_valid=4'b0100 and rsp_data=4'h9 at T+3 (ROM_LAT=1).
REQ-031 Full contention: req=4'b1111 held for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; responses in the same order with 2-cycle offset.
REQ-032 Priority: pri_en=1, req=4'b1011 held for 3 cycles -> gnt=4'b0001 on all three; then req=4'b1010 -> gnt=4'b0010, then 4'b1000.
REQ-033 Wrap-around: last winner 3, req=4'b0101 -> gnt=4'b0001, then 4'b0100.
REQ-034 Reset mid-flight: grant to requester 1 issued, reset pulsed low before its response -> rsp_valid stays 0, and after release req=4'b1111 grants requester 0 first.
REQ-035 ROM_LAT=3 instance: single request -> rsp_valid exactly 4 cycles after gnt; back-to-back requests every cycle produce back-to-back responses.
